// File: rtl/uart_rx.sv
// uart_rx: 8N1-style serial receiver with a first-word-fall-through receive FIFO.
// Detects a falling edge on the synchronized line and samples each bit mid-period.
// Received words are buffered in the FIFO; framing errors and overruns are sticky flags.
// Optional build macro UART_RX_MAJORITY_EN: decide each bit by a 2-of-3 vote around the
// sample point instead of a single sample.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | hunting for a falling edge on the synchronized line
// START | timing to mid start bit; high there means a glitch, back to IDLE
// DATA  | sampling DWIDTH data bits LSB-first, one full bit apart
// STOP  | sampling the stop bit; write, overrun or framing error, then IDLE
module uart_rx #(
    parameter int DIV    = 8,
    parameter int DWIDTH = 8,
    parameter int FDEPTH = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sIn,
    input  logic              rdEn,
    input  logic              clrErr,
    output logic [DWIDTH-1:0] dout,
    output logic              empty,
    output logic              fifoFull,
    output logic              frameErr,
    output logic              overrun
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int BW = (DWIDTH > 1) ? $clog2(DWIDTH) : 1;
    localparam int AW = $clog2(FDEPTH);

    // The decision cycle for DATA/STOP is the same in both builds: with the vote
    // every state entry is one cycle later, so the window stays centred on mid-bit.
    localparam logic [CW-1:0] CNT_BIT = CW'(DIV - 1);
`ifdef UART_RX_MAJORITY_EN
    localparam logic [CW-1:0] CNT_START = CW'(DIV / 2);
`else
    localparam logic [CW-1:0] CNT_START = CW'(DIV / 2 - 1);
`endif

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic              sync1_q, rx_s_q, rx_d_q;
    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
    logic [DWIDTH-1:0] shift_q, shift_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]       count_q, count_d;
    logic              frame_err_q, frame_err_d, overrun_q, overrun_d;
    logic [DWIDTH-1:0] mem [FDEPTH];
    logic              sample, push, pop, full, set_fe, set_ov;

`ifdef UART_RX_MAJORITY_EN
    logic rx_d2_q;

    // Third tap of the vote window.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rx_d2_q <= 1'b1;
        else      rx_d2_q <= rx_d_q;
    end

    assign sample = (rx_s_q & rx_d_q) | (rx_s_q & rx_d2_q) | (rx_d_q & rx_d2_q);
`else
    assign sample = rx_s_q;
`endif

    assign full     = (count_q == (AW+1)'(FDEPTH));
    assign pop      = rdEn && (count_q != '0);
    assign empty    = (count_q == '0);
    assign fifoFull = full;
    assign frameErr = frame_err_q;
    assign overrun  = overrun_q;
    assign dout     = mem[rd_ptr_q];

    // Next-state logic for the receive FSM, FIFO pointers and sticky flags.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        push        = 1'b0;
        set_fe      = 1'b0;
        set_ov      = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (rx_d_q && !rx_s_q) state_d = START;
            end
            START: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CNT_START) begin
                    cnt_d = '0;
                    if (!sample) begin
                        state_d   = DATA;
                        bit_cnt_d = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            DATA: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CNT_BIT) begin
                    cnt_d   = '0;
                    shift_d = {sample, shift_q[DWIDTH-1:1]};
                    if (bit_cnt_q == BW'(DWIDTH - 1)) state_d = STOP;
                    else                             bit_cnt_d = bit_cnt_q + BW'(1);
                end
            end
            STOP: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CNT_BIT) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                    if (sample) begin
                        // A pop in the same cycle frees a slot in a full FIFO.
                        if (!full || pop) push   = 1'b1;
                        else              set_ov = 1'b1;
                    end else begin
                        set_fe = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase

        frame_err_d = set_fe ? 1'b1 : (clrErr ? 1'b0 : frame_err_q);
        overrun_d   = set_ov ? 1'b1 : (clrErr ? 1'b0 : overrun_q);
    end

    // Synchronizer, FSM, counters, pointers and flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q     <= 1'b1;
            rx_s_q      <= 1'b1;
            rx_d_q      <= 1'b1;
            state_q     <= IDLE;
            cnt_q       <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            sync1_q     <= sIn;
            rx_s_q      <= sync1_q;
            rx_d_q      <= rx_s_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    // FIFO storage; cleared on reset so dout reads zero while empty after reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < FDEPTH; i++) mem[i] <= '0;
        end else if (push) begin
            mem[wr_ptr_q] <= shift_q;
        end
    end

endmodule
